step_cntr: RTL and testbench
============================

STEP_CNTR -- requirements
Module: step_cntr

Interface
REQ-001 The module SHALL have parameter STEP, default 1, meaning the unsigned increment or decrement applied per clock.
REQ-002 The module SHALL have parameter CNT_MODULE, default 10, meaning the count modulus; cnt ranges over 0..CNT_MODULE-1.
REQ-003 The module SHALL have parameter REVERSE, default 0, meaning 0 = count up and 1 = count down.
REQ-004 The module SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port RST, input, 1 bit, an asynchronous, active-low reset (0 = reset asserted).
REQ-006 The module SHALL have port cnt, output, W = $clog2(CNT_MODULE) bits, the registered counter value (e.g. 5 bits for 17, 3 bits for 8).
REQ-007 The module SHALL contain only one clock domain and no ports beyond CLK, RST and cnt.

Function
REQ-008 The module SHALL compute the effective step ES = STEP mod CNT_MODULE at elaboration.
REQ-009 With REVERSE=0, on each rising CLK edge while RST=1, the module SHALL set cnt to (cnt + ES) mod CNT_MODULE.
REQ-010 With REVERSE=1, on each rising CLK edge while RST=1, the module SHALL set cnt to (cnt - ES) mod CNT_MODULE, i.e. cnt + CNT_MODULE - ES when cnt < ES, else cnt - ES.
REQ-011 The module SHALL perform wrap arithmetic in at least W+1 bits so that intermediate sums never overflow, and SHALL never output a value >= CNT_MODULE.
REQ-012 The module SHALL handle the wrap correctly for any STEP, including STEP > CNT_MODULE and STEP = CNT_MODULE-1.
REQ-013 If ES = 0, cnt SHALL hold its value every cycle.
REQ-014 The module SHALL reflect each update on cnt in the same cycle as the clock edge (one register, no extra pipeline latency).
REQ-015 The module SHALL support CNT_MODULE being a power of two (e.g. 8) or not (e.g. 17) with identical semantics.
REQ-016 The module SHALL flag CNT_MODULE < 2 or STEP < 1 as an elaboration-time error.

Reset
REQ-017 While RST=0, cnt SHALL be 0 immediately and asynchronously, independent of CLK, for both REVERSE values.
REQ-018 After RST deasserts, the first rising CLK edge SHALL produce cnt = 0 + ES (forward) or (0 - ES) mod CNT_MODULE (reverse).
REQ-019 Asserting RST mid-count SHALL force cnt to 0 asynchronously, and counting SHALL restart from 0 after release.

Verification
REQ-020 STEP=3, CNT_MODULE=17, REVERSE=0, reset released -> cnt = 3,6,9,12,15,1,4,7,10,13,16,2,5,8,11,14,0,3...
REQ-021 STEP=3, CNT_MODULE=17, REVERSE=1 -> cnt = 14,11,8,5,2,16,13,10,7,4,1,15,12,9,6,3,0,14...
REQ-022 STEP=5, CNT_MODULE=8, REVERSE=1, with a 3-bit cnt -> cnt = 3,6,1,4,7,2,5,0,3...
REQ-023 Run all three configurations for 20 cycles, then drive RST=0 for 3 cycles at a time not aligned to a clock edge -> all cnt = 0 immediately and held; after release each sequence restarts per REQ-020..022.
REQ-024 STEP=10, CNT_MODULE=8 -> ES=2, cnt = 2,4,6,0 forward; STEP=8, CNT_MODULE=8 -> cnt held at 0.
REQ-025 Across all scenarios, an assertion checks every cycle that cnt < CNT_MODULE.

Source files
------------

// File: rtl/step_cntr.sv
// step_cntr: modulo counter that advances by a fixed step every clock.
//
// Parameters
//   STEP       - unsigned amount added (or subtracted) per clock; reduced modulo CNT_MODULE
//   CNT_MODULE - count modulus; cnt stays within 0..CNT_MODULE-1
//   REVERSE    - 0 counts up, 1 counts down
//
// Ports
//   CLK - clock, state updates on the rising edge
//   RST - asynchronous active-low reset, forces cnt to 0
//   cnt - registered counter value, $clog2(CNT_MODULE) bits wide
module step_cntr #(
  parameter int unsigned STEP       = 1,
  parameter int unsigned CNT_MODULE = 10,
  parameter int unsigned REVERSE    = 0,
  localparam int unsigned W         = $clog2(CNT_MODULE)
) (
  input  logic         CLK,
  input  logic         RST,
  output logic [W-1:0] cnt
);

  if (CNT_MODULE < 2 || STEP < 1) begin : g_bad_param
    $error("step_cntr: CNT_MODULE must be >= 2 and STEP must be >= 1");
  end

  // Effective step; a step that is a whole multiple of the modulus holds the count.
  localparam int unsigned ES = STEP % CNT_MODULE;

  // One extra bit so cnt + ES and cnt + CNT_MODULE can never overflow before the wrap.
  localparam logic [W:0] EsW  = (W+1)'(ES);
  localparam logic [W:0] ModW = (W+1)'(CNT_MODULE);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cur_w, nxt_w;

  always_comb begin
    cur_w = {1'b0, cnt_q};
    nxt_w = '0;
    if (REVERSE != 0) begin
      // Borrow: add the modulus back before subtracting so the result stays in range.
      if (cur_w < EsW) begin
        nxt_w = cur_w + ModW - EsW;
      end else begin
        nxt_w = cur_w - EsW;
      end
    end else begin
      nxt_w = cur_w + EsW;
      if (nxt_w >= ModW) begin
        nxt_w = nxt_w - ModW;
      end
    end
    cnt_d = nxt_w[W-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_step_cntr.sv
`timescale 1ns / 1ps
module tb_step_cntr;

  logic       CLK;
  logic       RST;
  logic [4:0] cnt_a;  // STEP=3,  M=17, up
  logic [4:0] cnt_b;  // STEP=3,  M=17, down
  logic [2:0] cnt_c;  // STEP=5,  M=8,  down
  logic [2:0] cnt_d;  // STEP=10, M=8,  up   (ES=2)
  logic [2:0] cnt_e;  // STEP=8,  M=8,  up   (ES=0)

  int total = 0;
  int bad   = 0;

  step_cntr #(.STEP(3),  .CNT_MODULE(17), .REVERSE(0)) u_a (.CLK(CLK), .RST(RST), .cnt(cnt_a));
  step_cntr #(.STEP(3),  .CNT_MODULE(17), .REVERSE(1)) u_b (.CLK(CLK), .RST(RST), .cnt(cnt_b));
  step_cntr #(.STEP(5),  .CNT_MODULE(8),  .REVERSE(1)) u_c (.CLK(CLK), .RST(RST), .cnt(cnt_c));
  step_cntr #(.STEP(10), .CNT_MODULE(8),  .REVERSE(0)) u_d (.CLK(CLK), .RST(RST), .cnt(cnt_d));
  step_cntr #(.STEP(8),  .CNT_MODULE(8),  .REVERSE(0)) u_e (.CLK(CLK), .RST(RST), .cnt(cnt_e));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Literal sequences after reset release (index 0 = first edge).
  int seq_a[18] = '{3, 6, 9, 12, 15, 1, 4, 7, 10, 13, 16, 2, 5, 8, 11, 14, 0, 3};
  int seq_b[18] = '{14, 11, 8, 5, 2, 16, 13, 10, 7, 4, 1, 15, 12, 9, 6, 3, 0, 14};
  int seq_c[9]  = '{3, 6, 1, 4, 7, 2, 5, 0, 3};
  int seq_d[4]  = '{2, 4, 6, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Closed-form model: after k edges the count is k*STEP taken modulo M, negated if reversed.
  function automatic int model(input int step, input int m, input int rev, input int k);
    int f;
    f = (k * (step % m)) % m;
    return (rev != 0) ? (m - f) % m : f;
  endfunction

  task automatic chk_model(input int k);
    chk($sformatf("a k=%0d", k), {27'd0, cnt_a}, model(3, 17, 0, k));
    chk($sformatf("b k=%0d", k), {27'd0, cnt_b}, model(3, 17, 1, k));
    chk($sformatf("c k=%0d", k), {29'd0, cnt_c}, model(5, 8, 1, k));
    chk($sformatf("d k=%0d", k), {29'd0, cnt_d}, model(10, 8, 0, k));
    chk($sformatf("e k=%0d", k), {29'd0, cnt_e}, model(8, 8, 0, k));
  endtask

  task automatic chk_seq(input int k);
    if (k >= 1 && k <= 18) begin
      chk($sformatf("seq_a k=%0d", k), {27'd0, cnt_a}, seq_a[k-1]);
      chk($sformatf("seq_b k=%0d", k), {27'd0, cnt_b}, seq_b[k-1]);
    end
    if (k >= 1 && k <= 9) chk($sformatf("seq_c k=%0d", k), {29'd0, cnt_c}, seq_c[k-1]);
    if (k >= 1 && k <= 4) chk($sformatf("seq_d k=%0d", k), {29'd0, cnt_d}, seq_d[k-1]);
    if (k >= 1) chk($sformatf("seq_e k=%0d", k), {29'd0, cnt_e}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a"}, {27'd0, cnt_a}, 0);
    chk({tag, " b"}, {27'd0, cnt_b}, 0);
    chk({tag, " c"}, {29'd0, cnt_c}, 0);
    chk({tag, " d"}, {29'd0, cnt_d}, 0);
    chk({tag, " e"}, {29'd0, cnt_e}, 0);
  endtask

  // Reset asserted part-way through a clock phase, held, then released on a falling edge.
  task automatic mid_reset(input int hold);
    @(posedge CLK);
    #($urandom_range(1, 3));
    RST = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (hold) begin
      @(negedge CLK);
      chk_zero("rst_hold");
    end
    RST = 1'b1;
  endtask

  // Range check on every cycle for every instance.
  always @(negedge CLK) begin
    chk("range a", {31'd0, cnt_a < 5'd17}, 1);
    chk("range b", {31'd0, cnt_b < 5'd17}, 1);
    chk("range c", {31'd0, cnt_c < 4'd8}, 1);
    chk("range d", {31'd0, cnt_d < 4'd8}, 1);
    chk("range e", {31'd0, cnt_e < 4'd8}, 1);
  end

  initial begin
    int runlen;
    RST = 1'b0;
    #3;
    chk_zero("reset_state");
    repeat (2) @(negedge CLK);
    chk_zero("reset_held");
    RST = 1'b1;

    // Directed run from reset release.
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      chk_model(k);
      chk_seq(k);
    end

    // Mid-count reset, then each sequence must restart.
    mid_reset(3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      chk_model(k);
      chk_seq(k);
    end

    // Random run lengths and random reset placement.
    for (int it = 0; it < 6; it++) begin
      mid_reset($urandom_range(1, 3));
      runlen = $urandom_range(5, 40);
      for (int k = 1; k <= runlen; k++) begin
        @(negedge CLK);
        chk_model(k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
